uart_tx_scheduler: RTL and testbench

Owns the single access port of the shared TX `fifo` and sequences every FIFO access. Writes come from `NUM_REQ` byte producers over valid/ready, chosen round-robin. Reads drain bytes through a one-entry hold register into the UART transmitter's start/busy handshake. The FIFO corrupts its count on a same-cycle write and read, and its `full`/`empty` flags lag by one cycle. The scheduler therefore never asserts both enables in one cycle and tracks occupancy itself.

---
 rtl/uart_fifo_pkg.sv | 31 +++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 45 ++++
 rtl/uart_tx_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types for the UART TX scheduler slice.
//   port_state_t : FIFO access-port sequencer states
//   tx_state_t   : UART transmitter handshake states
//   op_t         : last FIFO operation, used to alternate reads and writes
//   lvl_w()      : width of an occupancy counter able to hold 0..DEPTH
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    PIDLE     = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    READ_WAIT = 2'd3
  } port_state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority index this round (register lives in the caller)
//   grant     : one-hot grant, all zero when nothing requests
//   grant_idx : binary index of the granted requester
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                     req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                     grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [2*N-1:0] req2_s;
  logic           found_s;
  int             sel_s;

  // Rotate requests so ptr lands on bit 0, take the first set bit, map it back.
  always_comb begin
    req2_s  = {req, req} >> ptr;
    found_s = 1'b0;
    sel_s   = 32'sd0;
    for (int k = 0; k < N; k++) begin
      if (!found_s && req2_s[k]) begin
        found_s = 1'b1;
        sel_s   = int'(ptr) + k;
      end else begin
        found_s = found_s;
      end
    end
    if (sel_s >= N) begin
      sel_s = sel_s - N;
    end else begin
      sel_s = sel_s;
    end
    grant_idx = PW'(sel_s);
    for (int j = 0; j < N; j++) begin
      grant[j] = found_s && (sel_s == j);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Sole owner of the shared TX FIFO access port. Byte producers are accepted
// round-robin and written into the FIFO; bytes are read back through a
// one-entry hold register and handed to the UART transmitter. The FIFO
// misbehaves on a simultaneous write and read and its flags lag, so this
// block never issues both in one cycle and keeps its own occupancy count.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_data      : requester bytes (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   s_ready             : one-hot accept
//   fifo_wr_en/fifo_din : FIFO write port
//   fifo_rd_en/fifo_dout: FIFO read port, dout valid the cycle after rd_en
//   tx_start/tx_data    : one-cycle start pulse and byte to the UART TX
//   tx_busy             : UART TX shifting
//   level               : tracked FIFO occupancy
module uart_tx_scheduler
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [lvl_w(DEPTH)-1:0]       level
);

  localparam int LW = lvl_w(DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(32'd1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(32'd1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  port_state_t            port_state_r;
  tx_state_t              tx_state_r;
  op_t                    last_op_r;
  logic [PW-1:0]          rr_ptr_r;
  logic [PW-1:0]          grant_idx_r;
  logic [DATA_WIDTH-1:0]  hold_data_r;
  logic                   hold_full_r;

  logic                   rd_cand_s;
  logic                   wr_cand_s;
  logic                   pick_rd_s;
  logic [NUM_REQ-1:0]     arb_grant_s;
  logic [PW-1:0]          arb_idx_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;
  logic                   hold_set_s;
  logic                   hold_clr_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (s_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Candidate evaluation for the idle port; on a tie the op opposite to the last one wins.
  always_comb begin
    rd_cand_s = (level != {LW{1'b0}}) && !hold_full_r;
    wr_cand_s = (|s_valid) && (level < LVL_MAX);
    if (rd_cand_s && wr_cand_s) begin
      pick_rd_s = (last_op_r == OP_WR);
    end else if (rd_cand_s) begin
      pick_rd_s = 1'b1;
    end else begin
      pick_rd_s = 1'b0;
    end
  end

  // Byte of the requester the arbiter is currently granting.
  always_comb begin
    sel_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant_s[i]) begin
        sel_data_s = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Hold register handoff: filled after a read returns, emptied when TX takes the byte.
  always_comb begin
    hold_set_s = (port_state_r == READ_WAIT);
    hold_clr_s = (tx_state_r == TX_IDLE) && hold_full_r && !tx_busy;
  end

  // Port FSM: sequences FIFO writes and reads; enables are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_state_r <= PIDLE;
      last_op_r    <= OP_RD;
      rr_ptr_r     <= {PW{1'b0}};
      grant_idx_r  <= {PW{1'b0}};
      level        <= {LW{1'b0}};
      s_ready      <= {NUM_REQ{1'b0}};
      fifo_wr_en   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      fifo_din     <= {DATA_WIDTH{1'b0}};
    end else begin
      s_ready    <= {NUM_REQ{1'b0}};
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      case (port_state_r)
        PIDLE: begin
          if (pick_rd_s) begin
            port_state_r <= READ;
            fifo_rd_en   <= 1'b1;
          end else if (wr_cand_s) begin
            // Requesters hold data stable until accepted, so latching it here is safe.
            port_state_r <= WRITE;
            fifo_wr_en   <= 1'b1;
            s_ready      <= arb_grant_s;
            fifo_din     <= sel_data_s;
            grant_idx_r  <= arb_idx_s;
          end else begin
            port_state_r <= PIDLE;
          end
        end
        WRITE: begin
          level        <= level + LVL_ONE;
          last_op_r    <= OP_WR;
          port_state_r <= PIDLE;
          if (grant_idx_r == PTR_LAST) begin
            rr_ptr_r <= {PW{1'b0}};
          end else begin
            rr_ptr_r <= grant_idx_r + PTR_ONE;
          end
        end
        READ: begin
          level        <= level - LVL_ONE;
          last_op_r    <= OP_RD;
          port_state_r <= READ_WAIT;
        end
        READ_WAIT: begin
          port_state_r <= PIDLE;
        end
        default: begin
          port_state_r <= PIDLE;
        end
      endcase
    end
  end

  // Hold register: one prefetched byte waiting for the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {DATA_WIDTH{1'b0}};
    end else if (hold_set_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= fifo_dout;
    end else if (hold_clr_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // TX FSM: start pulse, then follow busy high and back low before the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= {DATA_WIDTH{1'b0}};
    end else begin
      tx_start <= 1'b0;
      case (tx_state_r)
        TX_IDLE: begin
          if (hold_clr_s) begin
            tx_state_r <= TX_START;
            tx_start   <= 1'b1;
            tx_data    <= hold_data_r;
          end else begin
            tx_state_r <= TX_IDLE;
          end
        end
        TX_START: begin
          tx_state_r <= TX_WAIT_HI;
        end
        TX_WAIT_HI: begin
          if (tx_busy) begin
            tx_state_r <= TX_WAIT_LO;
          end else begin
            tx_state_r <= TX_WAIT_HI;
          end
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            tx_state_r <= TX_IDLE;
          end else begin
            tx_state_r <= TX_WAIT_LO;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: accepted bytes are queued as the
// expected TX sequence; a monitor pops and compares on every tx_start. A
// behavioural FIFO and UART-busy model surround the DUT.
module tb_uart_tx_scheduler;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int NR = 2;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     s_valid = '0;
  logic [NR*DW-1:0]  s_data = '0;
  logic [NR-1:0]     s_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic              fifo_rd_en;
  logic [DW-1:0]     fifo_dout = '0;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy = 1'b0;
  logic [LW-1:0]     level;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];
  int acc_idx[$];
  int cyc = 0;
  int t0 = -1;
  int first_acc = -1;
  int first_tx = -1;
  int acc_count = 0;
  int tx_count = 0;
  int excl_err = 0;
  int hs_err = 0;
  int fifo_err = 0;
  int max_level = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  bit force_busy = 1'b0;
  bit rand_mode = 1'b0;
  bit saw_rd = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Engine: at every falling edge sample the DUT, model FIFO and UART, score, drive requesters.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rq0.delete(); rq1.delete(); exp_q.delete(); fq.delete(); acc_idx.delete();
        s_valid = '0; tx_busy = 1'b0; busy_cnt = 0; fifo_dout = '0;
        t0 = -1; first_acc = -1; first_tx = -1; acc_count = 0; tx_count = 0;
        excl_err = 0; hs_err = 0; fifo_err = 0; max_level = 0;
      end else begin
        if (fifo_wr_en && fifo_rd_en) excl_err++;
        if (((s_ready & ~s_valid) != '0) || ($countones(s_ready) > 1)) hs_err++;
        if (int'(level) > max_level) max_level = int'(level);
        if (fifo_rd_en) saw_rd = 1'b1;
        if (fifo_wr_en) begin
          if (fq.size() >= DEPTH) fifo_err++;
          fq.push_back(fifo_din);
        end
        if (fifo_rd_en) begin
          if (fq.size() == 0) fifo_err++;
          else fifo_dout = fq.pop_front();
        end
        tx_busy = force_busy || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) begin
          if (first_tx < 0) first_tx = cyc;
          tx_count++;
          busy_cnt = rand_mode ? int'($urandom_range(1, 6)) : busy_len;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_tx_data: got 0x%0h expected nothing", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_tx_data", int'(tx_data), int'(e));
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (s_valid[i] && s_ready[i]) begin
            exp_q.push_back(s_data[i*DW +: DW]);
            acc_idx.push_back(i);
            acc_count++;
            if (first_acc < 0) first_acc = cyc;
            s_valid[i] = 1'b0;
          end
        end
        if (rand_mode && ($urandom_range(0, 7) == 0)) begin
          if ($urandom_range(0, 1) == 0) begin
            if (rq0.size() < 4) rq0.push_back(8'($urandom));
          end else begin
            if (rq1.size() < 4) rq1.push_back(8'($urandom));
          end
        end
        if (!s_valid[0] && rq0.size() > 0) begin
          s_data[7:0] = rq0.pop_front();
          s_valid[0] = 1'b1;
          if (t0 < 0) t0 = cyc;
        end
        if (!s_valid[1] && rq1.size() > 0) begin
          s_data[15:8] = rq1.pop_front();
          s_valid[1] = 1'b1;
          if (t0 < 0) t0 = cyc;
        end
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    force_busy = 1'b0;
    rand_mode = 1'b0;
    busy_len = 3;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
      idle = (rq0.size() == 0) && (rq1.size() == 0) && (s_valid == '0) &&
             (exp_q.size() == 0) && (busy_cnt == 0) && !tx_busy &&
             !fifo_rd_en && !fifo_wr_en;
    end
    if (!idle) begin
      n_chk++;
      $display("FAIL %s: not idle after %0d cycles", name, n);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_wr_en"}, int'(fifo_wr_en), 0);
    chk({tag, "_rd_en"}, int'(fifo_rd_en), 0);
    chk({tag, "_din"}, int'(fifo_din), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_level"}, int'(level), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    do_reset();
    @(negedge clk); #1;
    check_zero("rst");

    // Single byte: accept in cycle 1, tx_start in cycle 6
    rq0.push_back(8'hA5);
    wait_idle(100, "single_idle");
    chk("single_acc_lat", first_acc - t0, 1);
    chk("single_tx_lat", first_tx - t0, 6);
    chk("single_acc_cnt", acc_count, 1);
    chk("single_tx_cnt", tx_count, 1);
    chk("single_level", int'(level), 0);

    // Round-robin with the transmitter held busy
    do_reset();
    force_busy = 1'b1;
    rq0.push_back(8'h11); rq0.push_back(8'h11);
    rq1.push_back(8'h22); rq1.push_back(8'h22);
    repeat (20) @(negedge clk);
    #1;
    chk("rr_count", acc_idx.size(), 4);
    if (acc_idx.size() == 4) begin
      chk("rr_order0", acc_idx[0], 0);
      chk("rr_order1", acc_idx[1], 1);
      chk("rr_order2", acc_idx[2], 0);
      chk("rr_order3", acc_idx[3], 1);
    end
    chk("rr_onehot", hs_err, 0);
    force_busy = 1'b0;
    wait_idle(200, "rr_idle");
    chk("rr_level", int'(level), 0);

    // Full: 20 bytes offered, 16 in the FIFO plus one held
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 20; i++) rq0.push_back(8'(8'h30 + i));
    repeat (80) @(negedge clk);
    #1;
    chk("full_acc", acc_count, 17);
    chk("full_level", int'(level), DEPTH);
    chk("full_ready", int'(s_ready), 0);
    repeat (10) @(negedge clk);
    #1;
    chk("full_acc_hold", acc_count, 17);
    force_busy = 1'b0;
    busy_len = 2;
    wait_idle(600, "full_idle");
    chk("full_acc_all", acc_count, 20);
    chk("full_level_end", int'(level), 0);
    chk("full_max_level", max_level, DEPTH);
    chk("full_fifo_model", fifo_err, 0);

    // Random traffic: mutual exclusion and ordering
    do_reset();
    rand_mode = 1'b1;
    repeat (10000) @(negedge clk);
    rand_mode = 1'b0;
    wait_idle(3000, "rand_idle");
    chk("rand_excl", excl_err, 0);
    chk("rand_handshake", hs_err, 0);
    chk("rand_fifo_model", fifo_err, 0);
    chk("rand_drained", tx_count, acc_count);
    chk("rand_activity", int'(acc_count > 100), 1);
    chk("rand_max_level", int'(max_level <= DEPTH), 1);

    // Mid-operation reset during READ_WAIT
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) rq0.push_back(8'(8'h61 + i));
    repeat (30) @(negedge clk);
    #1;
    chk("mr_acc", acc_count, 6);
    chk("mr_level_q", int'(level), 5);
    saw_rd = 1'b0;
    force_busy = 1'b0;
    n = 0;
    while (!saw_rd && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!saw_rd) begin
      n_chk++;
      $display("FAIL mr_read_seen: no READ within %0d cycles", n);
    end
    @(negedge clk); #2;
    chk("mr_level_pre", int'(level), 4);
    rst_n = 1'b0;
    #1;
    check_zero("mr");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    rq0.push_back(8'h5A);
    wait_idle(100, "mr_idle");
    chk("mr_acc_lat", first_acc - t0, 1);
    chk("mr_tx_lat", first_tx - t0, 6);
    chk("mr_tx_cnt", tx_count, 1);
    chk("mr_level_end", int'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
